// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit source: one-word holding buffer in front of a shifter,
// streaming WIDTH-bit words gap-free onto x with a valid/done qualifier.
module serial_bit_source #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    input  logic             abort,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hold_reg;
    logic             hold_full;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    cnt;

    // Bit number i of a word in transmission order.
    function automatic logic pick(input logic [WIDTH-1:0] w, input logic [CW-1:0] i);
        if (MSB_FIRST)
            return w[LAST - i];
        else
            return w[i];
    endfunction

    // ready mirrors !hold_full, so accept and drain can never coincide.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            hold_reg  <= '0;
            hold_full <= 1'b0;
            shift_reg <= '0;
            cnt       <= '0;
            ready     <= 1'b1;
            x         <= IDLE_LEVEL;
            x_valid   <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            hold_full <= 1'b0;
            cnt       <= '0;
            ready     <= 1'b1;
            x         <= IDLE_LEVEL;
            x_valid   <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (load && ready) begin
                hold_reg  <= din;
                hold_full <= 1'b1;
                ready     <= 1'b0;
            end
            case (state)
                IDLE: begin
                    x       <= IDLE_LEVEL;
                    x_valid <= 1'b0;
                    done    <= 1'b0;
                    if (hold_full) begin
                        state     <= SHIFT;
                        shift_reg <= hold_reg;
                        hold_full <= 1'b0;
                        ready     <= 1'b1;
                        cnt       <= '0;
                        x         <= pick(hold_reg, '0);
                        x_valid   <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt != LAST) begin
                        cnt  <= cnt + CW'(1);
                        x    <= pick(shift_reg, cnt + CW'(1));
                        done <= ((cnt + CW'(1)) == LAST);
                    end else if (hold_full) begin
                        // Next word follows immediately with no idle cycle.
                        shift_reg <= hold_reg;
                        hold_full <= 1'b0;
                        ready     <= 1'b1;
                        cnt       <= '0;
                        x         <= pick(hold_reg, '0);
                        done      <= 1'b0;
                    end else begin
                        state   <= IDLE;
                        cnt     <= '0;
                        x       <= IDLE_LEVEL;
                        x_valid <= 1'b0;
                        done    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = x_valid;

endmodule
